// File: rtl/axi_led_pwm_if.sv
// AXI4-Lite register bus (32-bit address/data) shared by the LED PWM block and its masters.
// aclk/aresetn are carried for the bus owner; the LED block runs on its own clk/rst.
interface AXI_LITE (
    input logic aclk,
    input logic aresetn
);
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport master (
        input  aclk, aresetn,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/axi_led_pwm.sv
// AXI-Lite controlled N-channel LED PWM: shared prescaler and PWM counter,
// per-channel duty/mode (off, PWM, blink-gated PWM).
module axi_led_pwm #(
    parameter int          N_LED        = 8,
    parameter int          PWM_BITS     = 8,
    parameter logic [15:0] PRESCALE_RST = 16'd195,
    parameter int          BLINK_DIV    = 64
) (
    input  logic             clk,
    input  logic             rst,
    AXI_LITE.slave           axi,
    output logic [N_LED-1:0] led
);
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [0:0]          wstate;
    logic [0:0]          rstate;
    logic                ctrl_en;
    logic [15:0]         prescale;
    logic [PWM_BITS-1:0] duty [N_LED];
    logic [1:0]          mode [N_LED];

    logic [15:0]         pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [15:0]         blink_cnt;
    logic                blink_phase;
    logic                tick;
    logic                period_end;
    logic [N_LED-1:0]    led_next;

    // Flat view of the register map indexed by addr[7:2]; shared by read mux and byte-merge on write.
    logic [31:0] reg_word [64];
    logic [63:0] reg_mapped;

    always_comb begin
        reg_word   = '{default: '0};
        reg_mapped = '0;
        reg_word[0] = {31'b0, ctrl_en};
        reg_word[1] = {16'b0, prescale};
        reg_word[2] = {19'b0, 5'(PWM_BITS), 2'b0, 6'(N_LED)};
        reg_mapped[2:0] = 3'b111;
        for (int unsigned i = 0; i < N_LED; i++) begin
            reg_word[6'(4 + i)]   = {14'b0, mode[i], 16'(duty[i])};
            reg_mapped[6'(4 + i)] = 1'b1;
        end
    end

    logic [5:0]  widx;
    logic [5:0]  ridx;
    logic        aw_hs;
    logic        ar_hs;
    logic [31:0] wmask;
    logic [31:0] wmerged;

    assign widx    = axi.awaddr[7:2];
    assign ridx    = axi.araddr[7:2];
    assign aw_hs   = (wstate == W_IDLE) && axi.awvalid && axi.wvalid;
    assign ar_hs   = (rstate == R_IDLE) && axi.arvalid;
    assign wmask   = {{8{axi.wstrb[3]}}, {8{axi.wstrb[2]}}, {8{axi.wstrb[1]}}, {8{axi.wstrb[0]}}};
    assign wmerged = (reg_word[widx] & ~wmask) | (axi.wdata & wmask);

    assign axi.awready = aw_hs;
    assign axi.wready  = aw_hs;
    assign axi.arready = ar_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate     <= W_IDLE;
            axi.bvalid <= 1'b0;
            axi.bresp  <= RESP_OKAY;
            ctrl_en    <= 1'b0;
            prescale   <= PRESCALE_RST;
            for (int unsigned i = 0; i < N_LED; i++) begin
                duty[i] <= '0;
                mode[i] <= '0;
            end
        end else if (wstate == W_IDLE) begin
            if (aw_hs) begin
                wstate     <= W_RESP;
                axi.bvalid <= 1'b1;
                axi.bresp  <= reg_mapped[widx] ? RESP_OKAY : RESP_SLVERR;
                if (widx == 6'd0) ctrl_en  <= wmerged[0];
                if (widx == 6'd1) prescale <= wmerged[15:0];
                for (int unsigned i = 0; i < N_LED; i++) begin
                    if (widx == 6'(4 + i)) begin
                        duty[i] <= wmerged[PWM_BITS-1:0];
                        mode[i] <= wmerged[17:16];
                    end
                end
            end
        end else if (axi.bready) begin
            wstate     <= W_IDLE;
            axi.bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate     <= R_IDLE;
            axi.rvalid <= 1'b0;
            axi.rresp  <= RESP_OKAY;
            axi.rdata  <= '0;
        end else if (rstate == R_IDLE) begin
            if (ar_hs) begin
                rstate     <= R_DATA;
                axi.rvalid <= 1'b1;
                axi.rresp  <= reg_mapped[ridx] ? RESP_OKAY : RESP_SLVERR;
                axi.rdata  <= reg_mapped[ridx] ? reg_word[ridx] : '0;
            end
        end else if (axi.rready) begin
            rstate     <= R_IDLE;
            axi.rvalid <= 1'b0;
        end
    end

    assign tick       = (pre_cnt == prescale);
    assign period_end = tick && (pwm_cnt == '1);

    // Disabling parks every counter at its restart value so re-enable is deterministic.
    always_ff @(posedge clk) begin
        if (rst || !ctrl_en) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end) begin
                if (blink_cnt == 16'(BLINK_DIV - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        led_next = '0;
        for (int unsigned i = 0; i < N_LED; i++) begin
            led_next[i] = ctrl_en && (pwm_cnt < duty[i]) &&
                          ((mode[i] == 2'd1) || ((mode[i] == 2'd2) && blink_phase));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) led <= '0;
        else     led <= led_next;
    end

    logic unused_bits;
    assign unused_bits = ^{axi.awaddr[31:8], axi.awaddr[1:0], axi.araddr[31:8], axi.araddr[1:0],
                           wmerged, axi.aclk, axi.aresetn};
endmodule
